// File: rtl/memoryunit_scheduler.sv
// Round-robin two-requester scheduler that serially writes a captured 16-bit
// word into the memoryunit cells, one bit per reclk edge, LSB first.
module memoryunit_scheduler #(
    parameter int WIDTH = 16,
    parameter int SLW   = 4
) (
    input  logic             reclk,
    input  logic             rst,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] wdata0,
    input  logic [WIDTH-1:0] wdata1,
    output logic [1:0]       gnt,
    output logic             busy,
    output logic [SLW-1:0]   sl,
    output logic             data,
    output logic             we,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    logic             lp;
    logic [WIDTH-1:0] buffer;
    logic             pick1;
    logic [WIDTH-1:0] win_word;
    logic [SLW-1:0]   next_sl;

    // On a tie the requester that did not win last time is served.
    always_comb begin
        pick1    = req[1] & (~req[0] | ~lp);
        win_word = pick1 ? wdata1 : wdata0;
        next_sl  = sl + SLW'(1);
    end

    always_ff @(posedge reclk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            lp     <= 1'b1;
            buffer <= '0;
            gnt    <= 2'b00;
            busy   <= 1'b0;
            sl     <= '0;
            data   <= 1'b0;
            we     <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (|req) begin
                        // Bit 0 comes straight from the winner's word, the buffer loads in parallel.
                        buffer <= win_word;
                        gnt    <= pick1 ? 2'b10 : 2'b01;
                        lp     <= pick1;
                        sl     <= '0;
                        data   <= win_word[0];
                        we     <= 1'b1;
                        busy   <= 1'b1;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (sl == SLW'(WIDTH - 1)) begin
                        state <= DONE;
                        we    <= 1'b0;
                        sl    <= '0;
                        data  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        sl   <= next_sl;
                        data <= buffer[next_sl];
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    gnt   <= 2'b00;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    gnt   <= 2'b00;
                    busy  <= 1'b0;
                    we    <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memoryunit_scheduler.sv
// Directed bench for memoryunit_scheduler: reconstructs each written word from
// the serial sl/data/we stream and compares against hand-computed vectors.
module tb_memoryunit_scheduler;

    logic        reclk;
    logic        rst;
    logic [1:0]  req;
    logic [15:0] wdata0;
    logic [15:0] wdata1;
    logic [1:0]  gnt;
    logic        busy;
    logic [3:0]  sl;
    logic        data;
    logic        we;
    logic        done;

    int checkCount = 0;
    int passCount  = 0;

    typedef struct {
        logic [1:0]  req;
        logic [15:0] w0;
        logic [15:0] w1;
        logic [1:0]  expGnt;
        logic [15:0] expWord;
        int          chgCycle;
        logic [15:0] chgW1;
        int          dropCycle;
    } vec_t;

    vec_t vecs[10];

    memoryunit_scheduler #(.WIDTH(16), .SLW(4)) dut (
        .reclk (reclk),
        .rst   (rst),
        .req   (req),
        .wdata0(wdata0),
        .wdata1(wdata1),
        .gnt   (gnt),
        .busy  (busy),
        .sl    (sl),
        .data  (data),
        .we    (we),
        .done  (done)
    );

    initial begin
        reclk = 1'b0;
        forever #5 reclk = ~reclk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp)
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        else
            passCount++;
    endtask

    task automatic applyStimulus(input logic [1:0] r, input logic [15:0] w0, input logic [15:0] w1);
        req    = r;
        wdata0 = w0;
        wdata1 = w1;
    endtask

    // One full transfer from IDLE: grant edge, 16 shift cycles, DONE, back to IDLE.
    task automatic runTransfer(input vec_t v);
        logic [15:0] got;
        int slBad;
        int holdBad;
        int idleBad;
        applyStimulus(v.req, v.w0, v.w1);
        @(posedge reclk); #1;
        checkOutput("grant", 32'(gnt), 32'(v.expGnt));
        checkOutput("busy_on", 32'(busy), 32'd1);
        got     = '0;
        slBad   = 0;
        holdBad = 0;
        for (int c = 1; c <= 16; c++) begin
            if (sl !== 4'(c - 1)) slBad++;
            if (we !== 1'b1 || done !== 1'b0 || gnt !== v.expGnt || busy !== 1'b1) holdBad++;
            got[c - 1] = data;
            if (c == v.chgCycle) wdata1 = v.chgW1;
            if (c == v.dropCycle) req = 2'b00;
            @(posedge reclk); #1;
        end
        checkOutput("sl_sequence", 32'(slBad), 32'd0);
        checkOutput("shift_hold", 32'(holdBad), 32'd0);
        checkOutput("written_word", 32'(got), 32'(v.expWord));
        checkOutput("done_pulse", 32'(done), 32'd1);
        checkOutput("we_off_done", 32'(we), 32'd0);
        checkOutput("gnt_held_done", 32'(gnt), 32'(v.expGnt));
        checkOutput("sl_zero_done", 32'(sl), 32'd0);
        @(posedge reclk); #1;
        checkOutput("idle_outputs", 32'({gnt, busy, done, we}), 32'd0);
        if (v.dropCycle != 0) begin
            idleBad = 0;
            repeat (3) begin
                @(posedge reclk); #1;
                if (gnt !== 2'b00 || busy !== 1'b0 || we !== 1'b0 || done !== 1'b0) idleBad++;
            end
            checkOutput("stay_idle", 32'(idleBad), 32'd0);
        end
    endtask

    initial begin
        int doneSeen;
        // {req, w0, w1, expGnt, expWord, chgCycle, chgW1, dropCycle}; lp starts at 1
        vecs[0] = '{2'b01, 16'hA5C3, 16'h0000, 2'b01, 16'hA5C3, 0, 16'h0000, 0};
        vecs[1] = '{2'b11, 16'h00FF, 16'hFF00, 2'b10, 16'hFF00, 0, 16'h0000, 0};
        vecs[2] = '{2'b11, 16'h00FF, 16'hFF00, 2'b01, 16'h00FF, 0, 16'h0000, 0};
        vecs[3] = '{2'b11, 16'h00FF, 16'hFF00, 2'b10, 16'hFF00, 0, 16'h0000, 0};
        vecs[4] = '{2'b10, 16'h0000, 16'h1234, 2'b10, 16'h1234, 0, 16'h0000, 0};
        vecs[5] = '{2'b11, 16'hBEEF, 16'h0001, 2'b01, 16'hBEEF, 0, 16'h0000, 0};
        vecs[6] = '{2'b01, 16'h8001, 16'h7777, 2'b01, 16'h8001, 0, 16'h0000, 0};
        vecs[7] = '{2'b11, 16'h0000, 16'hFFFF, 2'b10, 16'hFFFF, 0, 16'h0000, 0};
        vecs[8] = '{2'b10, 16'h0F0F, 16'h1234, 2'b10, 16'h1234, 5, 16'hFFFF, 0};
        vecs[9] = '{2'b01, 16'h5A5A, 16'h3C3C, 2'b01, 16'h5A5A, 0, 16'h0000, 3};

        // Reset held with requests pending and noisy words.
        rst = 1'b0;
        applyStimulus(2'b11, 16'h0000, 16'h0000);
        #1;
        for (int i = 0; i < 5; i++) begin
            wdata0 = 16'($urandom);
            wdata1 = 16'($urandom);
            @(posedge reclk); #1;
            checkOutput("reset_hold", 32'({gnt, busy, sl, data, we, done}), 32'd0);
        end
        applyStimulus(2'b00, 16'h0000, 16'h0000);
        rst = 1'b1;
        @(posedge reclk); #1;
        checkOutput("idle_no_req", 32'({gnt, busy, we, done}), 32'd0);

        for (int i = 0; i < 10; i++)
            runTransfer(vecs[i]);

        // Asynchronous reset in the middle of a requester-0 transfer.
        applyStimulus(2'b01, 16'hFFFF, 16'h0000);
        @(posedge reclk); #1;
        repeat (6) begin
            @(posedge reclk); #1;
        end
        checkOutput("mid_we_active", 32'({we, sl}), 32'({1'b1, 4'd6}));
        #2;
        rst = 1'b0;
        #1;
        checkOutput("async_reset_clear", 32'({gnt, busy, sl, data, we, done}), 32'd0);
        applyStimulus(2'b11, 16'hC0DE, 16'hDEAD);
        doneSeen = 0;
        repeat (2) begin
            @(posedge reclk); #1;
            if (done !== 1'b0 || we !== 1'b0) doneSeen++;
        end
        checkOutput("no_done_in_reset", 32'(doneSeen), 32'd0);
        rst = 1'b1;
        runTransfer('{2'b11, 16'hC0DE, 16'hDEAD, 2'b01, 16'hC0DE, 0, 16'h0000, 0});

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
